commit_packet_arbiter: RTL and testbench
========================================

Name: commit_packet_arbiter

Overview:
- Shares one issue slot's commit port between NUM_REQS execution-unit requesters (e.g. ALU, LSU, FPU, SFU).
- Sits upstream of the commit gather/fan-in stage.
- Multi-beat commits (sop..eop, one beat per lane-partition pid) are kept atomic: once a packet starts, the arbiter is locked to its requester until eop.
- Round-robin fairness is applied at packet granularity; the output is optionally registered through a 2-entry skid buffer.

Parameters:
- NUM_REQS, 4: number of requesting units (>=1).
- DATAW, 64: commit payload width in bits, excluding sop/eop.
- OUT_REG, 1: 1 = registered skid-buffer output; 0 = combinational pass-through.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQS  per-requester beat valid
- req_data  in  NUM_REQS*DATAW  per-requester payload; requester i occupies bits [i*DATAW +: DATAW]
- req_sop  in  NUM_REQS  first beat of packet
- req_eop  in  NUM_REQS  last beat of packet
- req_ready  out  NUM_REQS  per-requester accept
- out_valid  out  1  output beat valid
- out_data  out  DATAW  output payload
- out_sop  out  1  output first-beat flag
- out_eop  out  1  output last-beat flag
- out_ready  in  1  downstream accept
- grant_idx  out  LOG2UP(NUM_REQS)  requester of the beat accepted this cycle (meaningful when any req_valid&req_ready)
- locked  out  1  arbiter is mid-packet

Behaviour:
- Reset (asynchronous, active-high): out_valid=0, locked=0, priority pointer=0, skid buffer empty, req_ready=0 while reset is asserted.
  - Reset mid-packet discards the partial packet and any buffered beats.
- Transfer rule: a beat transfers on an input when req_valid[i]&req_ready[i], and on the output when out_valid&out_ready.
- Accept condition: can_accept = (OUT_REG ? buffer not full : out_ready).
  - Buffer fullness is a registered signal, so req_ready has no combinational path from out_ready when OUT_REG=1.
- State machine, IDLE / LOCKED (tracking register lock_idx):
  - IDLE:
    - Winner = first requester with req_valid, searching upward from the priority pointer with wrap-around.
    - req_ready[winner] = can_accept; all other req_ready bits are 0.
    - On transfer with eop=0: go to LOCKED with lock_idx=winner.
    - On transfer with eop=1: stay in IDLE and set pointer = (winner+1) mod NUM_REQS.
  - LOCKED:
    - req_ready[lock_idx] = can_accept; all others are 0, even when valid.
    - On an eop transfer: go to IDLE and set pointer = (lock_idx+1) mod NUM_REQS.
    - A non-eop transfer stays LOCKED.
- Arbitration and requester values:
  - Arbitration is combinational within the cycle; there is no idle cycle between packets.
  - The sop input does not affect arbitration. Simulation-only assertions check:
    - sop=1 on the first beat taken in IDLE;
    - sop=0 on beats taken in LOCKED.
  - A requester must hold valid, data, sop and eop stable until its beat is accepted (assertion).
- Latency and throughput:
  - OUT_REG=1: one cycle from input transfer to out_valid, and full throughput of one beat per cycle.
  - The skid buffer holds 2 entries. When out_ready is deasserted, the first stalled cycle still accepts one beat into the second entry.
  - OUT_REG=0: out_valid, out_data and out_eop are combinational from the granted requester; out_valid=0 when no request is pending.
- Simultaneous events:
  - When buffer full and out_ready are high in the same cycle, no input is accepted that cycle; full is registered.
  - An eop transfer and new requests arriving in the same cycle: the new requests are seen next cycle under the updated pointer.
- Edge cases:
  - NUM_REQS=1: always granted, grant_idx is 1 bit and always 0, lock logic is inert except for the locked output.
  - Pointer arithmetic wraps modulo NUM_REQS, including non-power-of-two values such as 3.

Decomposition:
- Shared package: a typedef for the {data, sop, eop} beat struct and the LOG2UP-based index width helper.
- Natural sub-module: commit_skid_buf, a 2-entry elastic buffer of width DATAW+2 with registered full and out_valid, instantiated only when OUT_REG=1.
- The round-robin search stays inline.

Test Plan:
- Single-beat contention, OUT_REG=1: NUM_REQS=4, all four requesters valid with sop=eop=1 and out_ready=1.
  - Required: grant order 0,1,2,3,0; out_valid rises 1 cycle after the first accept; one beat per cycle.
- Packet lock: req1 sends 3 beats (sop, -, eop) while req0 and req2 are held valid.
  - Required: req1's 3 beats appear contiguously on the output.
  - Required: req_ready[0] and req_ready[2] stay 0 until req1's eop transfers; the next grant goes to req2.
- Backpressure: out_ready=0 for 5 cycles during a 4-beat packet.
  - Required: exactly 2 beats are buffered, then req_ready=0.
  - Required: after out_ready=1, all 4 beats come out in order with none lost or duplicated.
- Asynchronous reset mid-packet: assert reset after beat 2 of a 4-beat packet from req3.
  - Required: out_valid and locked go to 0 immediately.
  - Required: after release with req0 and req3 both valid, req0 is granted (pointer=0).
- NUM_REQS=3, OUT_REG=0: a single-beat eop from req2.
  - Required: the pointer wraps to 0.
  - Required: out_valid and out_data equal req2's in the same cycle.
  - Required: with out_ready=0, req_ready=0 combinationally.

Source files
------------

// File: rtl/commit_packet_arbiter_pkg.sv
// Shared types and index helpers for the commit-port packet arbiter.
package commit_packet_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic sop;
    logic eop;
  } beat_flags_t;

  function automatic int log2up(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Modular add for requester indices; valid for idx < n and inc <= n.
  function automatic int wrap_add(input int idx, input int inc, input int n);
    int s;
    s = idx + inc;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/commit_skid_buf.sv
// Two-entry elastic buffer; full and out_valid come straight from registers.
module commit_skid_buf #(
  parameter int WIDTH = 66
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  logic             vld_p0, vld_p1;
  logic [WIDTH-1:0] data_p0, data_p1;
  logic             push, pop;

  assign push      = in_valid & ~vld_p1;
  assign pop       = vld_p0 & out_ready;
  assign in_ready  = ~vld_p1;
  assign out_valid = vld_p0;
  assign out_data  = data_p0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (vld_p0) vld_p1 <= 1'b1;
          else        vld_p0 <= 1'b1;
        end
        2'b01: begin
          vld_p0 <= vld_p1;
          vld_p1 <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Entry 0 is always the head; a simultaneous push and pop refills it directly.
  always_ff @(posedge clk) begin
    case ({push, pop})
      2'b10: begin
        if (vld_p0) data_p1 <= in_data;
        else        data_p0 <= in_data;
      end
      2'b01: data_p0 <= data_p1;
      2'b11: data_p0 <= in_data;
      default: ;
    endcase
  end

endmodule

// File: rtl/commit_packet_arbiter.sv
// Round-robin commit-port arbiter with packet locking from sop to eop and an
// optional two-entry registered output stage.
module commit_packet_arbiter
  import commit_packet_arbiter_pkg::*;
#(
  parameter int  NUM_REQS = 4,
  parameter int  DATAW    = 64,
  parameter bit  OUT_REG  = 1'b1,
  localparam int IDXW     = log2up(NUM_REQS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQS-1:0]       req_valid,
  input  logic [NUM_REQS*DATAW-1:0] req_data,
  input  logic [NUM_REQS-1:0]       req_sop,
  input  logic [NUM_REQS-1:0]       req_eop,
  output logic [NUM_REQS-1:0]       req_ready,
  output logic                      out_valid,
  output logic [DATAW-1:0]          out_data,
  output logic                      out_sop,
  output logic                      out_eop,
  input  logic                      out_ready,
  output logic [IDXW-1:0]           grant_idx,
  output logic                      locked
);

  typedef struct packed {
    logic [DATAW-1:0] data;
    beat_flags_t      flags;
  } beat_t;

  arb_state_e      state;
  logic [IDXW-1:0] ptr, lock_idx, winner, cand, sel, sel_next;
  logic            have_winner, grant_en, can_accept, beat_valid, xfer;
  beat_t           beat;

  always_comb begin
    winner      = '0;
    have_winner = 1'b0;
    cand        = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      cand = IDXW'(wrap_add(int'(ptr), i, NUM_REQS));
      if (!have_winner && req_valid[cand]) begin
        winner      = cand;
        have_winner = 1'b1;
      end
    end
  end

  assign sel        = (state == ARB_LOCKED) ? lock_idx : winner;
  assign sel_next   = IDXW'(wrap_add(int'(sel), 1, NUM_REQS));
  assign grant_en   = ~reset & ((state == ARB_LOCKED) | have_winner);
  assign beat_valid = grant_en & req_valid[sel];
  assign beat       = {req_data[int'(sel)*DATAW +: DATAW], req_sop[sel], req_eop[sel]};
  assign req_ready  = (grant_en & can_accept) ? (NUM_REQS'(1) << sel) : '0;
  assign xfer       = beat_valid & can_accept;
  assign grant_idx  = sel;
  assign locked     = (state == ARB_LOCKED);

  generate
    if (OUT_REG) begin : g_out_reg
      logic [DATAW+1:0] skid_out;
      logic             skid_ready;

      commit_skid_buf #(.WIDTH(DATAW + 2)) u_skid (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (beat_valid),
        .in_data   (beat),
        .in_ready  (skid_ready),
        .out_valid (out_valid),
        .out_data  (skid_out),
        .out_ready (out_ready)
      );

      assign can_accept                   = skid_ready;
      assign {out_data, out_sop, out_eop} = skid_out;
    end else begin : g_out_comb
      assign can_accept = out_ready;
      assign out_valid  = beat_valid;
      assign out_data   = beat.data;
      assign out_sop    = beat.flags.sop;
      assign out_eop    = beat.flags.eop;
    end
  endgenerate

  // The pointer only advances at packet boundaries, so fairness is per packet.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ARB_IDLE;
      ptr      <= '0;
      lock_idx <= '0;
    end else if (xfer) begin
      if (state == ARB_IDLE) begin
        if (beat.flags.eop) begin
          ptr <= sel_next;
        end else begin
          state    <= ARB_LOCKED;
          lock_idx <= sel;
        end
      end else if (beat.flags.eop) begin
        state <= ARB_IDLE;
        ptr   <= sel_next;
      end
    end
  end

`ifndef SYNTHESIS
  a_sop_first: assert property (@(posedge clk) disable iff (reset)
    (xfer && state == ARB_IDLE) |-> beat.flags.sop);
  a_sop_cont: assert property (@(posedge clk) disable iff (reset)
    (xfer && state == ARB_LOCKED) |-> !beat.flags.sop);

  for (genvar g = 0; g < NUM_REQS; g++) begin : g_hold
    a_hold: assert property (@(posedge clk) disable iff (reset)
      (req_valid[g] && !req_ready[g]) |=>
        (req_valid[g] && $stable(req_data[g*DATAW +: DATAW]) &&
         $stable(req_sop[g]) && $stable(req_eop[g])));
  end
`endif

endmodule

// File: tb/tb_commit_packet_arbiter.sv
// Directed bench: 4-requester registered arbiter plus a 3-requester pass-through one.
module tb_commit_packet_arbiter;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [3:0]   req_valid = '0, req_sop = '0, req_eop = '0, req_ready;
  logic [255:0] req_data = '0;
  logic         out_valid, out_sop, out_eop, out_ready = 1'b0, locked;
  logic [63:0]  out_data;
  logic [1:0]   grant_idx;

  logic [2:0]   r3_valid = '0, r3_sop = '0, r3_eop = '0, r3_ready;
  logic [47:0]  r3_data = '0;
  logic         r3_out_valid, r3_out_sop, r3_out_eop, r3_out_ready = 1'b0, r3_locked;
  logic [15:0]  r3_out_data;
  logic [1:0]   r3_grant;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  commit_packet_arbiter #(.NUM_REQS(4), .DATAW(64), .OUT_REG(1'b1)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_sop(req_sop), .req_eop(req_eop), .req_ready(req_ready),
    .out_valid(out_valid), .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop),
    .out_ready(out_ready), .grant_idx(grant_idx), .locked(locked)
  );

  commit_packet_arbiter #(.NUM_REQS(3), .DATAW(16), .OUT_REG(1'b0)) dut3 (
    .clk(clk), .reset(reset), .req_valid(r3_valid), .req_data(r3_data),
    .req_sop(r3_sop), .req_eop(r3_eop), .req_ready(r3_ready),
    .out_valid(r3_out_valid), .out_data(r3_out_data), .out_sop(r3_out_sop),
    .out_eop(r3_out_eop), .out_ready(r3_out_ready), .grant_idx(r3_grant), .locked(r3_locked)
  );

  function automatic logic [63:0] mk(input int r, input int n);
    return 64'hC0DE_0000_0000_0000 | (64'(r) << 8) | 64'(n);
  endfunction

  task automatic set_req(input int r, input logic v, input logic s, input logic e,
                         input logic [63:0] d);
    req_valid[r] = v;
    req_sop[r]   = s;
    req_eop[r]   = e;
    req_data[r*64 +: 64] = d;
  endtask

  task automatic set_r3(input int r, input logic v, input logic [15:0] d);
    r3_valid[r] = v;
    r3_sop[r]   = v;
    r3_eop[r]   = v;
    r3_data[r*16 +: 16] = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    out_ready = 1'b1;
    for (int r = 0; r < 4; r++) set_req(r, 1'b1, 1'b1, 1'b1, mk(r, 0));
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL reset_locked got %b want 0", locked); end
    n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_req_ready got %b want 0000", req_ready); end
    n_cmp++; if (r3_out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_r3_out_valid got %b want 0", r3_out_valid); end
    req_valid = '0;
    step();
    reset = 1'b0;
    #1;
    n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL idle_req_ready got %b want 0000", req_ready); end
  endtask

  task automatic test_contention();
    int order[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int cnt[4]   = '{0, 0, 0, 0};
    int r;
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'b1, 1'b1, mk(i, 0));
    #1;
    for (int k = 0; k < 8; k++) begin
      n_cmp++; if (grant_idx !== 2'(order[k])) begin n_bad++; $display("FAIL rr_grant k=%0d got %0d want %0d", k, grant_idx, order[k]); end
      n_cmp++; if (req_ready !== 4'(1 << order[k])) begin n_bad++; $display("FAIL rr_ready k=%0d got %b want %b", k, req_ready, 4'(1 << order[k])); end
      n_cmp++; if (out_valid !== (k > 0)) begin n_bad++; $display("FAIL rr_out_valid k=%0d got %b want %b", k, out_valid, k > 0); end
      if (k > 0) begin
        n_cmp++; if (out_data !== mk(order[k-1], (k-1)/4)) begin n_bad++; $display("FAIL rr_out_data k=%0d got %h want %h", k, out_data, mk(order[k-1], (k-1)/4)); end
      end
      step();
      r = order[k];
      cnt[r]++;
      if (cnt[r] == 2) set_req(r, 1'b0, 1'b0, 1'b0, '0);
      else             set_req(r, 1'b1, 1'b1, 1'b1, mk(r, cnt[r]));
      #1;
    end
    n_cmp++; if (out_valid !== 1'b1 || out_data !== mk(3, 1)) begin n_bad++; $display("FAIL rr_last got %b/%h want 1/%h", out_valid, out_data, mk(3, 1)); end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rr_drain got %b want 0", out_valid); end
  endtask

  task automatic test_packet_lock();
    set_req(0, 1'b1, 1'b1, 1'b1, mk(0, 7));
    #1;
    n_cmp++; if (grant_idx !== 2'd0) begin n_bad++; $display("FAIL lock_prep_grant got %0d want 0", grant_idx); end
    step();
    set_req(0, 1'b1, 1'b1, 1'b1, mk(0, 9));
    set_req(2, 1'b1, 1'b1, 1'b1, mk(2, 9));
    set_req(1, 1'b1, 1'b1, 1'b0, mk(1, 32));
    #1;
    n_cmp++; if (grant_idx !== 2'd1 || req_ready !== 4'b0010) begin n_bad++; $display("FAIL lock_first got %0d/%b want 1/0010", grant_idx, req_ready); end
    step();
    set_req(1, 1'b1, 1'b0, 1'b0, mk(1, 33));
    #1;
    n_cmp++; if (locked !== 1'b1 || req_ready !== 4'b0010) begin n_bad++; $display("FAIL lock_mid1 got %b/%b want 1/0010", locked, req_ready); end
    n_cmp++; if (out_data !== mk(1, 32) || out_sop !== 1'b1) begin n_bad++; $display("FAIL lock_out0 got %h/%b want %h/1", out_data, out_sop, mk(1, 32)); end
    step();
    set_req(1, 1'b1, 1'b0, 1'b1, mk(1, 34));
    #1;
    n_cmp++; if (req_ready !== 4'b0010) begin n_bad++; $display("FAIL lock_mid2 got %b want 0010", req_ready); end
    n_cmp++; if (out_data !== mk(1, 33)) begin n_bad++; $display("FAIL lock_out1 got %h want %h", out_data, mk(1, 33)); end
    step();
    set_req(1, 1'b0, 1'b0, 1'b0, '0);
    #1;
    n_cmp++; if (locked !== 1'b0 || grant_idx !== 2'd2 || req_ready !== 4'b0100) begin n_bad++; $display("FAIL lock_next got %b/%0d/%b want 0/2/0100", locked, grant_idx, req_ready); end
    n_cmp++; if (out_data !== mk(1, 34) || out_eop !== 1'b1) begin n_bad++; $display("FAIL lock_out2 got %h/%b want %h/1", out_data, out_eop, mk(1, 34)); end
    step();
    set_req(2, 1'b0, 1'b0, 1'b0, '0);
    #1;
    n_cmp++; if (grant_idx !== 2'd0 || out_data !== mk(2, 9)) begin n_bad++; $display("FAIL lock_after got %0d/%h want 0/%h", grant_idx, out_data, mk(2, 9)); end
    step();
    set_req(0, 1'b0, 1'b0, 1'b0, '0);
    #1;
    n_cmp++; if (out_valid !== 1'b1 || out_data !== mk(0, 9)) begin n_bad++; $display("FAIL lock_tail got %b/%h want 1/%h", out_valid, out_data, mk(0, 9)); end
    step();
  endtask

  task automatic test_backpressure();
    bit rdy_exp[11] = '{1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0};
    bit ov_exp[11]  = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    int oi_exp[11]  = '{0, 0, 0, 0, 0, 0, 0, 1, 2, 3, 0};
    int b = 0;
    logic acc;
    for (int cyc = 0; cyc < 11; cyc++) begin
      out_ready = !(cyc >= 1 && cyc <= 5);
      if (b < 4) set_req(1, 1'b1, b == 0, b == 3, mk(1, 64 + b));
      else       set_req(1, 1'b0, 1'b0, 1'b0, '0);
      #1;
      n_cmp++; if (req_ready !== (rdy_exp[cyc] ? 4'b0010 : 4'b0000)) begin n_bad++; $display("FAIL bp_ready cyc=%0d got %b want %b", cyc, req_ready, rdy_exp[cyc]); end
      n_cmp++; if (out_valid !== ov_exp[cyc]) begin n_bad++; $display("FAIL bp_out_valid cyc=%0d got %b want %b", cyc, out_valid, ov_exp[cyc]); end
      if (ov_exp[cyc]) begin
        n_cmp++; if (out_data !== mk(1, 64 + oi_exp[cyc])) begin n_bad++; $display("FAIL bp_out_data cyc=%0d got %h want %h", cyc, out_data, mk(1, 64 + oi_exp[cyc])); end
      end
      acc = req_valid[1] & req_ready[1];
      step();
      if (acc) b++;
    end
    n_cmp++; if (locked !== 1'b0) begin n_bad++; $display("FAIL bp_unlocked got %b want 0", locked); end
  endtask

  task automatic test_reset_mid_packet();
    out_ready = 1'b1;
    set_req(3, 1'b1, 1'b1, 1'b0, mk(3, 80));
    #1;
    n_cmp++; if (grant_idx !== 2'd3) begin n_bad++; $display("FAIL rst_pkt_grant got %0d want 3", grant_idx); end
    step();
    set_req(3, 1'b1, 1'b0, 1'b0, mk(3, 81));
    #1;
    n_cmp++; if (locked !== 1'b1) begin n_bad++; $display("FAIL rst_pkt_locked got %b want 1", locked); end
    step();
    set_req(3, 1'b1, 1'b0, 1'b0, mk(3, 82));
    #1;
    n_cmp++; if (out_valid !== 1'b1 || out_data !== mk(3, 81)) begin n_bad++; $display("FAIL rst_pkt_pre got %b/%h want 1/%h", out_valid, out_data, mk(3, 81)); end
    reset = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || locked !== 1'b0) begin n_bad++; $display("FAIL rst_async got %b/%b want 0/0", out_valid, locked); end
    n_cmp++; if (req_ready !== 4'b0000) begin n_bad++; $display("FAIL rst_async_ready got %b want 0000", req_ready); end
    set_req(3, 1'b1, 1'b1, 1'b1, mk(3, 90));
    set_req(0, 1'b1, 1'b1, 1'b1, mk(0, 90));
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    n_cmp++; if (grant_idx !== 2'd0 || req_ready !== 4'b0001 || out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_release got %0d/%b/%b want 0/0001/0", grant_idx, req_ready, out_valid); end
    step();
    set_req(0, 1'b0, 1'b0, 1'b0, '0);
    #1;
    n_cmp++; if (grant_idx !== 2'd3 || out_data !== mk(0, 90)) begin n_bad++; $display("FAIL rst_second got %0d/%h want 3/%h", grant_idx, out_data, mk(0, 90)); end
    step();
    set_req(3, 1'b0, 1'b0, 1'b0, '0);
    #1;
    n_cmp++; if (out_data !== mk(3, 90)) begin n_bad++; $display("FAIL rst_third got %h want %h", out_data, mk(3, 90)); end
    step();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_drain got %b want 0", out_valid); end
  endtask

  task automatic test_three_comb();
    r3_out_ready = 1'b1;
    set_r3(2, 1'b1, 16'h2A2A);
    #1;
    n_cmp++; if (r3_out_valid !== 1'b1 || r3_out_data !== 16'h2A2A) begin n_bad++; $display("FAIL n3_comb_out got %b/%h want 1/2a2a", r3_out_valid, r3_out_data); end
    n_cmp++; if (r3_grant !== 2'd2 || r3_ready !== 3'b100) begin n_bad++; $display("FAIL n3_grant got %0d/%b want 2/100", r3_grant, r3_ready); end
    r3_out_ready = 1'b0;
    #1;
    n_cmp++; if (r3_ready !== 3'b000 || r3_out_valid !== 1'b1) begin n_bad++; $display("FAIL n3_stall got %b/%b want 000/1", r3_ready, r3_out_valid); end
    r3_out_ready = 1'b1;
    step();
    for (int i = 0; i < 3; i++) set_r3(i, 1'b1, 16'h3000 | 16'(i));
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (r3_grant !== 2'(i)) begin n_bad++; $display("FAIL n3_wrap_grant i=%0d got %0d want %0d", i, r3_grant, i); end
      n_cmp++; if (r3_out_data !== (16'h3000 | 16'(i))) begin n_bad++; $display("FAIL n3_wrap_data i=%0d got %h want %h", i, r3_out_data, 16'h3000 | 16'(i)); end
      step();
      set_r3(i, 1'b0, '0);
    end
    #1;
    n_cmp++; if (r3_out_valid !== 1'b0) begin n_bad++; $display("FAIL n3_idle got %b want 0", r3_out_valid); end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_contention();
    test_packet_lock();
    test_backpressure();
    test_reset_mid_packet();
    test_three_comb();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
